change_dispenser: RTL

Converts the change amount computed by the vending controller into individual coin-eject requests. Accepts a start pulse with a 16-bit amount in cents and dispenses it greedily from largest to smallest denomination, tracking per-denomination coin stock. Handshakes each coin with the external coin ejector and reports any unpaid remainder. Sits between the vending controller's change output and the coin-ejector hardware.

---
 rtl/vending_pkg.sv | 38 +++
 rtl/change_dispenser_if.sv | 35 +++
 rtl/change_coin_picker.sv | 25 ++
 rtl/change_dispenser.sv | 117 +++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared vending definitions: money width, denomination codes/values and
// the change-dispenser state encoding.
package vending_pkg;

    localparam int MONEY_W   = 16;
    localparam int NUM_DENOM = 6;

    typedef logic [MONEY_W-1:0] money_t;
    typedef logic [2:0]         denom_code_t;

    localparam denom_code_t CODE_500 = 3'd0;
    localparam denom_code_t CODE_100 = 3'd1;
    localparam denom_code_t CODE_25  = 3'd2;
    localparam denom_code_t CODE_10  = 3'd3;
    localparam denom_code_t CODE_5   = 3'd4;
    localparam denom_code_t CODE_1   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_FINISH
    } disp_state_t;

    // Unused codes map to zero, so they never qualify for selection.
    function automatic money_t coin_value(input denom_code_t code);
        case (code)
            CODE_500: coin_value = 16'd500;
            CODE_100: coin_value = 16'd100;
            CODE_25:  coin_value = 16'd25;
            CODE_10:  coin_value = 16'd10;
            CODE_5:   coin_value = 16'd5;
            CODE_1:   coin_value = 16'd1;
            default:  coin_value = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of start/coin-handshake/refill/status signals between the vending
// controller, the coin ejector and the change dispenser.
interface change_dispenser_if #(
    parameter int STOCK_W = 8
);
    import vending_pkg::*;

    logic               I_START;
    money_t             I_AMOUNT;
    logic               O_COIN_VALID;
    logic [2:0]         O_COIN_SEL;
    logic               I_COIN_ACK;
    logic               I_REFILL;
    logic [2:0]         I_REFILL_SEL;
    logic [STOCK_W-1:0] I_REFILL_CNT;
    logic [STOCK_W-1:0] O_STOCK;
    logic               O_BUSY;
    logic               O_DONE;
    logic               O_SHORT;
    money_t             O_REMAIN;
    logic [7:0]         O_COIN_COUNT;

    modport slave (
        input  I_START, I_AMOUNT, I_COIN_ACK, I_REFILL, I_REFILL_SEL, I_REFILL_CNT,
        output O_COIN_VALID, O_COIN_SEL, O_STOCK, O_BUSY, O_DONE, O_SHORT,
               O_REMAIN, O_COIN_COUNT
    );

    modport master (
        output I_START, I_AMOUNT, I_COIN_ACK, I_REFILL, I_REFILL_SEL, I_REFILL_CNT,
        input  O_COIN_VALID, O_COIN_SEL, O_STOCK, O_BUSY, O_DONE, O_SHORT,
               O_REMAIN, O_COIN_COUNT
    );

endinterface

// File: rtl/change_coin_picker.sv
// Greedy priority selector: lowest code (largest coin) that fits the
// remaining amount and still has stock.
module change_coin_picker
    import vending_pkg::*;
(
    input  money_t                 remain,
    input  logic [NUM_DENOM-1:0]   stock_nz,
    output logic                   found,
    output denom_code_t            code
);

    // Scan from the smallest coin up so the lowest qualifying code wins.
    always_comb begin
        found = 1'b0;
        code  = CODE_500;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (stock_nz[i] && (coin_value(denom_code_t'(i)) <= remain)
                && (coin_value(denom_code_t'(i)) != 16'd0)) begin
                found = 1'b1;
                code  = denom_code_t'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Dispenses a change amount coin by coin through the ejector handshake,
// tracking per-denomination stock and reporting any unpaid remainder.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 20
) (
    input  logic                CLK,
    input  logic                I_RESET,
    change_dispenser_if.slave   bus
);

    disp_state_t          state;
    logic [STOCK_W-1:0]   stock     [NUM_DENOM];
    logic [STOCK_W-1:0]   stock_nxt [NUM_DENOM];
    logic [STOCK_W:0]     stock_sum;
    logic [NUM_DENOM-1:0] stock_nz;
    logic                 pick_found;
    denom_code_t          pick_code;
    logic                 ack_take;

    change_coin_picker u_picker (
        .remain   (bus.O_REMAIN),
        .stock_nz (stock_nz),
        .found    (pick_found),
        .code     (pick_code)
    );

    assign ack_take   = (state == S_ISSUE) && bus.O_COIN_VALID && bus.I_COIN_ACK;
    assign bus.O_BUSY = (state != S_IDLE);

    // Per-denomination next stock: ack decrement and refill may coincide.
    always_comb begin
        stock_sum = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            stock_sum = {1'b0, stock[i]};
            if (bus.I_REFILL && (bus.I_REFILL_SEL == 3'(i)))
                stock_sum = stock_sum + {1'b0, bus.I_REFILL_CNT};
            if (ack_take && (bus.O_COIN_SEL == 3'(i)))
                stock_sum = stock_sum - {{STOCK_W{1'b0}}, 1'b1};
            stock_nxt[i] = stock_sum[STOCK_W] ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
            stock_nz[i]  = (stock[i] != '0);
        end
    end

    always_comb begin
        bus.O_STOCK = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (bus.I_REFILL_SEL == 3'(i))
                bus.O_STOCK = stock[i];
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (I_RESET)
                stock[i] <= STOCK_W'(INIT_STOCK);
            else
                stock[i] <= stock_nxt[i];
        end
    end

    // S_FINISH spends two cycles: raise O_DONE, then return to idle so that
    // O_BUSY falls in the cycle after the done pulse.
    always_ff @(posedge CLK) begin
        if (I_RESET) begin
            state            <= S_IDLE;
            bus.O_COIN_VALID <= 1'b0;
            bus.O_COIN_SEL   <= '0;
            bus.O_DONE       <= 1'b0;
            bus.O_SHORT      <= 1'b0;
            bus.O_REMAIN     <= '0;
            bus.O_COIN_COUNT <= '0;
        end else begin
            bus.O_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.I_START) begin
                        bus.O_REMAIN     <= bus.I_AMOUNT;
                        bus.O_COIN_COUNT <= '0;
                        bus.O_SHORT      <= 1'b0;
                        state            <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pick_found) begin
                        bus.O_COIN_SEL   <= pick_code;
                        bus.O_COIN_VALID <= 1'b1;
                        state            <= S_ISSUE;
                    end else begin
                        state <= S_FINISH;
                    end
                end
                S_ISSUE: begin
                    if (ack_take) begin
                        bus.O_REMAIN     <= bus.O_REMAIN - coin_value(bus.O_COIN_SEL);
                        if (bus.O_COIN_COUNT != 8'hFF)
                            bus.O_COIN_COUNT <= bus.O_COIN_COUNT + 8'd1;
                        bus.O_COIN_VALID <= 1'b0;
                        state            <= S_SELECT;
                    end
                end
                S_FINISH: begin
                    if (!bus.O_DONE) begin
                        bus.O_DONE  <= 1'b1;
                        bus.O_SHORT <= (bus.O_REMAIN != '0);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
